// File: rtl/bus_master.sv
// rtl/bus_master.sv - Wishbone single-transfer bus master with timeout and registered outputs
module bus_master #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [ADR_WIDTH-1:0] adr_i,
    input  logic [DAT_WIDTH-1:0] wdat_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 timeout_o,
    output logic [DAT_WIDTH-1:0] rdat_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic                 m_we_o,
    output logic [ADR_WIDTH-1:0] m_adr_o,
    output logic [DAT_WIDTH-1:0] m_dat_o,
    input  logic [DAT_WIDTH-1:0] m_dat_i,
    input  logic                 m_ack_i,
    input  logic                 m_err_i
);

    // Counter just wide enough to hold TIMEOUT; it saturates there instead of wrapping.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 busy_d, done_d, err_d, timeout_d;
    logic                 cyc_d, stb_d, we_d;
    logic [ADR_WIDTH-1:0] adr_d;
    logic [DAT_WIDTH-1:0] dat_d, rdat_d;

    // Register the state and every output so nothing combinational reaches the ports.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            timeout_o <= 1'b0;
            rdat_o    <= '0;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            err_o     <= err_d;
            timeout_o <= timeout_d;
            rdat_o    <= rdat_d;
            m_cyc_o   <= cyc_d;
            m_stb_o   <= stb_d;
            m_we_o    <= we_d;
            m_adr_o   <= adr_d;
            m_dat_o   <= dat_d;
        end
    end

    // Next-state and next-output logic; everything holds by default and done is a single pulse.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        busy_d    = busy_o;
        done_d    = 1'b0;
        err_d     = err_o;
        timeout_d = timeout_o;
        rdat_d    = rdat_o;
        cyc_d     = m_cyc_o;
        stb_d     = m_stb_o;
        we_d      = m_we_o;
        adr_d     = m_adr_o;
        dat_d     = m_dat_o;
        case (state)
            IDLE: begin
                if (req_i) begin
                    adr_d   = adr_i;
                    we_d    = we_i;
                    dat_d   = wdat_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (m_err_i) begin
                    // Error takes priority over a coincident ack; read data is not trusted.
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = RELEASE;
                end else if (m_ack_i) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    if (!m_we_o) begin
                        rdat_d = m_dat_i;
                    end
                    state_d   = RELEASE;
                end else if (cnt == CNT_MAX) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                // One guaranteed stb-low cycle before IDLE can accept the next request.
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - scoreboard testbench for bus_master
module tb_bus_master;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_i, we_i;
    logic [AW-1:0] adr_i;
    logic [DW-1:0] wdat_i;
    logic          busy_o, done_o, err_o, timeout_o;
    logic [DW-1:0] rdat_o;
    logic          m_cyc_o, m_stb_o, m_we_o;
    logic [AW-1:0] m_adr_o;
    logic [DW-1:0] m_dat_o, m_dat_i;
    logic          m_ack_i, m_err_i;

    // slave behaviour: 0 silent, 1 ack, 2 err, 3 ack and err together
    logic [1:0]    slv_mode;
    logic [DW-1:0] slv_dat;

    typedef struct {
        logic          err;
        logic          to;
        logic [DW-1:0] rdat;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    bus_master #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
        .wdat_i(wdat_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .timeout_o(timeout_o), .rdat_o(rdat_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i)
    );

    assign m_dat_i = slv_dat ^ {{(DW-AW){1'b0}}, m_adr_o};

    // registered slave: responds one cycle after seeing the strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack_i <= 1'b0;
            m_err_i <= 1'b0;
        end else begin
            m_ack_i <= m_stb_o && !m_ack_i && !m_err_i && slv_mode[0];
            m_err_i <= m_stb_o && !m_ack_i && !m_err_i && slv_mode[1];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse is matched against the oldest expected completion
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_err", 64'(err_o), 64'(e.err));
                check("sb_timeout", 64'(timeout_o), 64'(e.to));
                check("sb_rdat", rdat_o, e.rdat);
            end
        end
    end

    task automatic push_exp(input logic err, input logic to, input logic [DW-1:0] rdat);
        exp_t e;
        e.err = err; e.to = to; e.rdat = rdat;
        exp_q.push_back(e);
    endtask

    // one transfer: returns latency (sample edge = 1), strobe cycles and bus values seen in stb
    task automatic do_xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                           input logic [1:0] mode, output int lat, output int stb_cyc,
                           output logic s_we, output logic [AW-1:0] s_adr,
                           output logic [DW-1:0] s_dat, output logic ok);
        @(negedge clk);
        slv_mode = mode; we_i = we; adr_i = adr; wdat_i = wdat; req_i = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0;
        lat = 1; stb_cyc = 0; ok = 1'b0;
        s_we = m_we_o; s_adr = m_adr_o; s_dat = m_dat_o;
        if (m_stb_o) stb_cyc++;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done_o) ok = 1'b1;
            else if (m_stb_o) stb_cyc++;
        end
        if (!ok) begin
            n_checks++;
            n_fails++;
            $display("FAIL xfer_bound: got no done_o within 40 cycles expected done_o");
        end
        @(posedge clk); #1;
    endtask

    int            lat, stbc;
    logic          s_we, ok;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;

    initial begin
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; adr_i = '0; wdat_i = '0;
        slv_mode = 2'd0; slv_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 0);
        check("rst_done", 64'(done_o), 0);
        check("rst_err", 64'(err_o), 0);
        check("rst_timeout", 64'(timeout_o), 0);
        check("rst_stb", 64'(m_stb_o), 0);
        check("rst_cyc", 64'(m_cyc_o), 0);
        check("rst_adr", 64'(m_adr_o), 0);
        check("rst_rdat", rdat_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // read with ack
        slv_dat = 64'h0280400000100210;
        push_exp(1'b0, 1'b0, 64'h0280400000100210);
        do_xfer(1'b0, 16'h0000, '0, 2'd1, lat, stbc, s_we, s_adr, s_dat, ok);
        check("read_latency", 64'(lat), 3);
        check("read_stb_cycles", 64'(stbc), 2);
        check("read_we", 64'(s_we), 0);
        check("read_busy_after", 64'(busy_o), 0);

        // write terminated by slave error
        push_exp(1'b1, 1'b0, 64'h0280400000100210);
        do_xfer(1'b1, 16'h0028, 64'h1234, 2'd2, lat, stbc, s_we, s_adr, s_dat, ok);
        check("write_we", 64'(s_we), 1);
        check("write_dat", s_dat, 64'h1234);
        check("write_adr", 64'(s_adr), 64'h28);

        // timeout with a silent slave
        push_exp(1'b1, 1'b1, 64'h0280400000100210);
        do_xfer(1'b0, 16'h0040, '0, 2'd0, lat, stbc, s_we, s_adr, s_dat, ok);
        check("timeout_stb_cycles", 64'(stbc), 9);
        check("timeout_stb_low", 64'(m_stb_o), 0);
        repeat (2) @(posedge clk);
        #1;
        check("timeout_err_held", 64'(err_o), 1);
        check("timeout_flag_held", 64'(timeout_o), 1);

        // ack and err in the same cycle: err wins, read data discarded
        slv_dat = 64'hDEAD_BEEF_CAFE_F00D;
        push_exp(1'b1, 1'b0, 64'h0280400000100210);
        do_xfer(1'b0, 16'h0000, '0, 2'd3, lat, stbc, s_we, s_adr, s_dat, ok);

        // back-to-back reads with req held high
        begin
            int            dones, rises, gap, min_gap;
            logic          prev_stb;
            logic [AW-1:0] adr2;
            dones = 0; rises = 0; gap = 0; min_gap = 99; adr2 = '0;
            @(negedge clk);
            slv_mode = 2'd1; slv_dat = 64'h1111_2222_3333_4440;
            we_i = 1'b0; adr_i = 16'h0000; req_i = 1'b1;
            push_exp(1'b0, 1'b0, 64'h1111_2222_3333_4440);
            push_exp(1'b0, 1'b0, 64'h1111_2222_3333_4448);
            @(posedge clk); #1;
            adr_i = 16'h0008;
            prev_stb = m_stb_o;
            for (int i = 0; i < 40 && dones < 2; i++) begin
                @(posedge clk); #1;
                if (done_o) dones++;
                if (m_stb_o && !prev_stb) begin
                    rises++;
                    min_gap = gap;
                    adr2 = m_adr_o;
                    req_i = 1'b0;
                end
                if (!m_stb_o) gap++;
                else gap = 0;
                prev_stb = m_stb_o;
            end
            req_i = 1'b0;
            @(posedge clk); #1;
            check("b2b_dones", 64'(dones), 2);
            check("b2b_second_strobe", 64'(rises), 1);
            check("b2b_gap_ge2", 64'(min_gap >= 2), 1);
            check("b2b_adr2", 64'(adr2), 64'h0008);
        end

        // reset asserted mid-strobe abandons the transfer
        @(negedge clk);
        slv_mode = 2'd0; we_i = 1'b0; adr_i = 16'h0030; req_i = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_stb", 64'(m_stb_o), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_stb", 64'(m_stb_o), 0);
        check("async_rst_cyc", 64'(m_cyc_o), 0);
        check("async_rst_busy", 64'(busy_o), 0);
        check("async_rst_rdat", rdat_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_stb", 64'(m_stb_o), 0);
        check("post_rst_done", 64'(done_o), 0);

        // transfer after reset proves the FSM is back in IDLE
        slv_dat = 64'hFEED_FACE_0000_0000;
        push_exp(1'b0, 1'b0, 64'hFEED_FACE_0000_0010);
        do_xfer(1'b0, 16'h0010, '0, 2'd1, lat, stbc, s_we, s_adr, s_dat, ok);
        check("post_rst_latency", 64'(lat), 3);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #50000;
        $display("FAIL watchdog: got no completion by 50000 expected test end");
        $fatal(1);
    end

endmodule
